sobel_frame_writer: RTL

- Sink end of the Sobel pixel stream: captures each (grayscale_i, done_i) strobe from the Sobel kernel output into an on-chip frame buffer in raster order.
- After a full output frame is written, streams it out over a valid/ready handshake to the downstream consumer (UART transmitter or display path), then re-arms for the next frame.

---
 rtl/sobel_pkg.sv | 17 +
 rtl/sobel_frame_ram.sv | 32 +++
 rtl/sobel_frame_writer.sv | 115 +++++++++++
 3 files changed

// File: rtl/sobel_pkg.sv
// Shared types and default geometry for the Sobel frame writer.
// The write/readout FSM states live here so the testbench can import the same names.
package sobel_pkg;

  typedef enum logic [1:0] {
    WRITE   = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2
  } state_e;

  localparam int PIX_W         = 8;
  localparam int DEF_OUT_W     = 254;
  localparam int DEF_OUT_H     = 254;
  localparam int DEF_FRAME_PIX = DEF_OUT_W * DEF_OUT_H;
  localparam int DEF_ADDR_W    = $clog2(DEF_FRAME_PIX);

endpackage

// File: rtl/sobel_frame_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port.
// The read register only updates when re_i is high, so its output holds between reads.
module sobel_frame_ram
  import sobel_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [PIX_W-1:0]  wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [PIX_W-1:0]  rdata_o
);

  logic [PIX_W-1:0] mem [2**ADDR_W];
  logic [PIX_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sobel_frame_writer.sv
// Captures one Sobel output frame in raster order, then streams it out over valid/ready.
// Handshake: a pixel transfers on a rising edge where rd_valid_o and rd_ready_i are both high.
module sobel_frame_writer
  import sobel_pkg::*;
#(
  parameter int OUT_W  = DEF_OUT_W,
  parameter int OUT_H  = DEF_OUT_H,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] grayscale_i,
  input  logic             done_i,
  output logic [PIX_W-1:0] rd_data_o,
  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  output logic             frame_done_o,
  output logic             readout_done_o,
  output logic             overflow_o,
  output logic             busy_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(OUT_W * OUT_H - 1);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  state_e            state_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              rd_valid_q;
  logic              frame_done_q;
  logic              readout_done_q;
  logic              overflow_q;
  logic              busy_q;

  logic              ram_we;
  logic              ram_re;

  assign ram_we = done_i && (state_q == WRITE);
  assign ram_re = (state_q == FETCH);

  sobel_frame_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (ram_we),
    .waddr_i (wr_addr_q),
    .wdata_i (grayscale_i),
    .re_i    (ram_re),
    .raddr_i (rd_addr_q),
    .rdata_o (rd_data_o)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= WRITE;
      wr_addr_q      <= '0;
      rd_addr_q      <= '0;
      rd_valid_q     <= 1'b0;
      frame_done_q   <= 1'b0;
      readout_done_q <= 1'b0;
      overflow_q     <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      frame_done_q   <= 1'b0;
      readout_done_q <= 1'b0;
      // Any strobe outside WRITE is lost, including the final-acceptance cycle.
      if (done_i && (state_q != WRITE)) overflow_q <= 1'b1;

      case (state_q)
        WRITE: begin
          if (done_i) begin
            if (wr_addr_q == LAST_ADDR) begin
              wr_addr_q    <= '0;
              rd_addr_q    <= '0;
              frame_done_q <= 1'b1;
              busy_q       <= 1'b1;
              state_q      <= FETCH;
            end else begin
              wr_addr_q <= wr_addr_q + ONE;
            end
          end
        end
        FETCH: begin
          rd_valid_q <= 1'b1;
          state_q    <= PRESENT;
        end
        PRESENT: begin
          if (rd_ready_i) begin
            rd_valid_q <= 1'b0;
            if (rd_addr_q == LAST_ADDR) begin
              readout_done_q <= 1'b1;
              busy_q         <= 1'b0;
              state_q        <= WRITE;
            end else begin
              rd_addr_q <= rd_addr_q + ONE;
              state_q   <= FETCH;
            end
          end
        end
        default: begin
          state_q <= WRITE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rd_valid_o     = rd_valid_q;
  assign frame_done_o   = frame_done_q;
  assign readout_done_o = readout_done_q;
  assign overflow_o     = overflow_q;
  assign busy_o         = busy_q;

endmodule
